// File: rtl/ex_mem_stage_if.sv
// Signal bundle for the EX/MEM stage: EX-side inputs, data-memory handshake and write-back outputs.
// The stage uses the slave view; the driving environment uses the master view.
interface ex_mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    logic              ex_valid;
    logic              ex_wen;
    logic [REG_W-1:0]  ex_wsel;
    logic              ex_memToReg;
    logic              ex_jl;
    logic              ex_dREN;
    logic              ex_dWEN;
    logic              ex_halt;
    logic [DATA_W-1:0] ex_aluOut;
    logic [DATA_W-1:0] ex_storeData;
    logic [DATA_W-1:0] ex_incPC;
    logic              enable;
    logic              flush;
    logic              dhit;
    logic [DATA_W-1:0] dmemload;
    logic              dmemREN;
    logic              dmemWEN;
    logic [DATA_W-1:0] dmemaddr;
    logic [DATA_W-1:0] dmemstore;
    logic              mem_busy;
    logic              wb_valid;
    logic              wb_wen;
    logic [REG_W-1:0]  wb_wsel;
    logic [DATA_W-1:0] wb_wdat;
    logic              halt;
    logic [CNT_W-1:0]  stall_cnt;

    modport slave (
        input  ex_valid, ex_wen, ex_wsel, ex_memToReg, ex_jl, ex_dREN, ex_dWEN, ex_halt,
               ex_aluOut, ex_storeData, ex_incPC, enable, flush, dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_busy,
               wb_valid, wb_wen, wb_wsel, wb_wdat, halt, stall_cnt
    );

    modport master (
        output ex_valid, ex_wen, ex_wsel, ex_memToReg, ex_jl, ex_dREN, ex_dWEN, ex_halt,
               ex_aluOut, ex_storeData, ex_incPC, enable, flush, dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_busy,
               wb_valid, wb_wen, wb_wsel, wb_wdat, halt, stall_cnt
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with data-memory handshake FSM, sticky halt and saturating stall counter.
// state    | meaning
// S_IDLE   | no memory request outstanding
// S_ACCESS | M slot holds a load/store, request driven until dhit
// S_HALTED | halt retired, nothing further is latched or retired
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    ex_mem_stage_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_HALTED} state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_m_valid;
    logic              r_m_wen;
    logic [REG_W-1:0]  r_m_wsel;
    logic              r_m_mem_to_reg;
    logic              r_m_jl;
    logic              r_m_dren;
    logic              r_m_dwen;
    logic              r_m_halt;
    logic [DATA_W-1:0] r_m_alu_out;
    logic [DATA_W-1:0] r_m_store_data;
    logic [DATA_W-1:0] r_m_inc_pc;
    logic              r_halt;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_mem_busy;
    logic              w_dren;
    logic              w_dwen;
    logic [DATA_W-1:0] w_addr;
    logic [DATA_W-1:0] w_store;
    logic              w_adv;
    logic              w_wb_valid;
    logic              w_halt_retire;
    logic              w_latch;
    logic              w_in_valid;
    logic              w_in_mem;
    logic              w_stall;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_mem_busy  = 1'b0;
        w_dren      = 1'b0;
        w_dwen      = 1'b0;
        w_addr      = '0;
        w_store     = '0;
        w_state_nxt = r_state;

        case (r_state)
            S_ACCESS: begin
                w_dren     = r_m_dren;
                w_dwen     = r_m_dwen;
                w_addr     = r_m_alu_out;
                w_store    = r_m_store_data;
                w_mem_busy = !bus.dhit;
            end
            S_HALTED: w_mem_busy = 1'b1;
            default:  ;
        endcase

        w_in_valid    = bus.ex_valid & !bus.flush;
        w_in_mem      = w_in_valid & (bus.ex_dREN | bus.ex_dWEN);
        w_adv         = bus.enable & !w_mem_busy & (r_state != S_HALTED);
        w_wb_valid    = r_m_valid & !w_mem_busy & (r_state != S_HALTED);
        w_halt_retire = w_wb_valid & r_m_halt;
        // The retiring halt stays in M so the write-back outputs hold its fields.
        w_latch       = w_adv & !w_halt_retire;
        w_stall       = (r_state == S_ACCESS) & !bus.dhit;

        if (w_halt_retire) begin
            w_state_nxt = S_HALTED;
        end else begin
            case (r_state)
                S_IDLE:   if (w_adv && w_in_mem) w_state_nxt = S_ACCESS;
                S_ACCESS: if (bus.dhit && w_adv) w_state_nxt = w_in_mem ? S_ACCESS : S_IDLE;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_m_valid      <= 1'b0;
            r_m_wen        <= 1'b0;
            r_m_wsel       <= '0;
            r_m_mem_to_reg <= 1'b0;
            r_m_jl         <= 1'b0;
            r_m_dren       <= 1'b0;
            r_m_dwen       <= 1'b0;
            r_m_halt       <= 1'b0;
            r_m_alu_out    <= '0;
            r_m_store_data <= '0;
            r_m_inc_pc     <= '0;
        end else if (w_latch) begin
            r_m_valid      <= w_in_valid;
            r_m_wen        <= w_in_valid & bus.ex_wen;
            r_m_wsel       <= w_in_valid ? bus.ex_wsel : '0;
            r_m_mem_to_reg <= w_in_valid & bus.ex_memToReg;
            r_m_jl         <= w_in_valid & bus.ex_jl;
            r_m_dren       <= w_in_valid & bus.ex_dREN;
            r_m_dwen       <= w_in_valid & bus.ex_dWEN;
            r_m_halt       <= w_in_valid & bus.ex_halt;
            r_m_alu_out    <= w_in_valid ? bus.ex_aluOut : '0;
            r_m_store_data <= w_in_valid ? bus.ex_storeData : '0;
            r_m_inc_pc     <= w_in_valid ? bus.ex_incPC : '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_halt      <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_halt_retire) r_halt <= 1'b1;
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.dmemREN   = w_dren;
    assign bus.dmemWEN   = w_dwen;
    assign bus.dmemaddr  = w_addr;
    assign bus.dmemstore = w_store;
    assign bus.mem_busy  = w_mem_busy;
    assign bus.wb_valid  = w_wb_valid;
    // Stores never write the register file.
    assign bus.wb_wen    = w_wb_valid & r_m_wen & !r_m_dwen;
    assign bus.wb_wsel   = r_m_wsel;
    assign bus.wb_wdat   = r_m_mem_to_reg ? bus.dmemload : (r_m_jl ? r_m_inc_pc : r_m_alu_out);
    assign bus.halt      = r_halt;
    assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: ALU, load stall, store/load back-to-back, flush during access,
// JAL/halt, reset mid-access and stall counter saturation.
module tb_ex_mem_stage;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 16;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    ex_mem_stage_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    ex_mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_clear();
        bus.ex_valid     = 1'b0;
        bus.ex_wen       = 1'b0;
        bus.ex_wsel      = '0;
        bus.ex_memToReg  = 1'b0;
        bus.ex_jl        = 1'b0;
        bus.ex_dREN      = 1'b0;
        bus.ex_dWEN      = 1'b0;
        bus.ex_halt      = 1'b0;
        bus.ex_aluOut    = '0;
        bus.ex_storeData = '0;
        bus.ex_incPC     = '0;
    endtask

    task automatic ex_lw(input logic [4:0] wsel, input logic [31:0] addr);
        ex_clear();
        bus.ex_valid    = 1'b1;
        bus.ex_wen      = 1'b1;
        bus.ex_memToReg = 1'b1;
        bus.ex_dREN     = 1'b1;
        bus.ex_wsel     = wsel;
        bus.ex_aluOut   = addr;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst = 1'b1;
        ex_clear();
        bus.enable   = 1'b1;
        bus.flush    = 1'b0;
        bus.dhit     = 1'b0;
        bus.dmemload = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_busy", bus.mem_busy, 0);
        chk("rst_halt", bus.halt, 0);
        chk("rst_stall", bus.stall_cnt, 0);
        chk("rst_dren", bus.dmemREN, 0);

        // ADD
        ex_clear();
        bus.ex_valid  = 1'b1;
        bus.ex_wen    = 1'b1;
        bus.ex_wsel   = 5'd5;
        bus.ex_aluOut = 32'h10;
        tick();
        ex_clear();
        #1;
        chk("add_wb_valid", bus.wb_valid, 1);
        chk("add_wsel", bus.wb_wsel, 5);
        chk("add_wdat", bus.wb_wdat, 32'h10);
        chk("add_busy", bus.mem_busy, 0);
        chk("add_wen", bus.wb_wen, 1);

        // LW with three wait cycles
        ex_lw(5'd8, 32'h100);
        tick();
        ex_clear();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_dren", bus.dmemREN, 1);
            chk("lw_busy", bus.mem_busy, 1);
            chk("lw_wbv_wait", bus.wb_valid, 0);
            tick();
        end
        chk("lw_addr", bus.dmemaddr, 32'h100);
        bus.dhit     = 1'b1;
        bus.dmemload = 32'hDEADBEEF;
        #1;
        chk("lw_hit_busy", bus.mem_busy, 0);
        chk("lw_wb_valid", bus.wb_valid, 1);
        chk("lw_wdat", bus.wb_wdat, 32'hDEADBEEF);
        chk("lw_stall_cnt", bus.stall_cnt, 3);
        tick();
        bus.dhit = 1'b0;
        #1;
        chk("lw_idle_dren", bus.dmemREN, 0);

        // SW then LW back-to-back
        ex_clear();
        bus.ex_valid     = 1'b1;
        bus.ex_wen       = 1'b1;
        bus.ex_dWEN      = 1'b1;
        bus.ex_aluOut    = 32'h200;
        bus.ex_storeData = 32'hCAFE;
        tick();
        ex_lw(5'd9, 32'h204);
        #1;
        chk("sw_dwen", bus.dmemWEN, 1);
        chk("sw_addr", bus.dmemaddr, 32'h200);
        chk("sw_data", bus.dmemstore, 32'hCAFE);
        chk("sw_busy", bus.mem_busy, 1);
        tick();
        bus.dhit = 1'b1;
        #1;
        chk("sw_wb_valid", bus.wb_valid, 1);
        chk("sw_wb_wen", bus.wb_wen, 0);
        tick();
        ex_clear();
        bus.dhit = 1'b0;
        #1;
        chk("b2b_dren", bus.dmemREN, 1);
        chk("b2b_dwen", bus.dmemWEN, 0);
        chk("b2b_addr", bus.dmemaddr, 32'h204);
        bus.dhit     = 1'b1;
        bus.dmemload = 32'h12345678;
        #1;
        chk("b2b_wdat", bus.wb_wdat, 32'h12345678);
        chk("b2b_wsel", bus.wb_wsel, 9);
        tick();
        bus.dhit = 1'b0;
        #1;
        chk("b2b_stall_cnt", bus.stall_cnt, 4);
        chk("b2b_idle_dren", bus.dmemREN, 0);

        // flush / enable toggling while LW waits
        ex_lw(5'd10, 32'h300);
        tick();
        ex_clear();
        bus.ex_valid  = 1'b1;
        bus.ex_wen    = 1'b1;
        bus.ex_wsel   = 5'd11;
        bus.ex_aluOut = 32'h77;
        bus.flush     = 1'b1;
        bus.enable    = 1'b0;
        #1;
        chk("fl_dren", bus.dmemREN, 1);
        chk("fl_busy", bus.mem_busy, 1);
        tick();
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        tick();
        chk("fl_held_dren", bus.dmemREN, 1);
        chk("fl_held_addr", bus.dmemaddr, 32'h300);
        bus.enable   = 1'b1;
        bus.dhit     = 1'b1;
        bus.dmemload = 32'hABCD;
        #1;
        chk("fl_wb_valid", bus.wb_valid, 1);
        chk("fl_wdat", bus.wb_wdat, 32'hABCD);
        chk("fl_wsel", bus.wb_wsel, 10);
        tick();
        ex_clear();
        bus.flush = 1'b0;
        bus.dhit  = 1'b0;
        #1;
        chk("fl_bubble_wbv", bus.wb_valid, 0);
        chk("fl_bubble_dren", bus.dmemREN, 0);
        chk("fl_stall_cnt", bus.stall_cnt, 7);

        // JAL then HALT
        ex_clear();
        bus.ex_valid  = 1'b1;
        bus.ex_wen    = 1'b1;
        bus.ex_jl     = 1'b1;
        bus.ex_wsel   = 5'd31;
        bus.ex_incPC  = 32'h44;
        bus.ex_aluOut = 32'h999;
        tick();
        ex_clear();
        bus.ex_valid = 1'b1;
        bus.ex_halt  = 1'b1;
        #1;
        chk("jal_wdat", bus.wb_wdat, 32'h44);
        chk("jal_wsel", bus.wb_wsel, 31);
        chk("jal_wbv", bus.wb_valid, 1);
        tick();
        ex_clear();
        bus.ex_valid  = 1'b1;
        bus.ex_wen    = 1'b1;
        bus.ex_wsel   = 5'd3;
        bus.ex_aluOut = 32'h55;
        #1;
        chk("halt_retire_wbv", bus.wb_valid, 1);
        chk("halt_pre", bus.halt, 0);
        tick();
        chk("halt_set", bus.halt, 1);
        chk("halt_busy", bus.mem_busy, 1);
        chk("halt_wbv", bus.wb_valid, 0);
        bus.dhit = 1'b1;
        tick();
        tick();
        chk("halt_sticky", bus.halt, 1);
        chk("halt_ignore_wbv", bus.wb_valid, 0);
        chk("halt_ignore_wsel", bus.wb_wsel, 0);
        chk("halt_dren", bus.dmemREN, 0);

        // reset out of HALTED and mid-ACCESS
        rst = 1'b1;
        bus.dhit = 1'b0;
        ex_clear();
        tick();
        rst = 1'b0;
        #1;
        chk("rst2_halt", bus.halt, 0);
        chk("rst2_busy", bus.mem_busy, 0);
        chk("rst2_stall", bus.stall_cnt, 0);
        ex_lw(5'd12, 32'h400);
        tick();
        ex_clear();
        #1;
        chk("rst_acc_dren", bus.dmemREN, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_acc_dren0", bus.dmemREN, 0);
        chk("rst_acc_addr0", bus.dmemaddr, 0);
        chk("rst_acc_busy0", bus.mem_busy, 0);
        chk("rst_acc_wbv0", bus.wb_valid, 0);
        chk("rst_acc_wdat0", bus.wb_wdat, 0);
        chk("rst_acc_stall0", bus.stall_cnt, 0);

        // stall counter saturation
        ex_lw(5'd13, 32'h404);
        tick();
        ex_clear();
        repeat (65540) tick();
        chk("sat_cnt", bus.stall_cnt, 32'hFFFF);
        chk("sat_busy", bus.mem_busy, 1);
        bus.dhit     = 1'b1;
        bus.dmemload = 32'h5A5A;
        #1;
        chk("sat_wbv", bus.wb_valid, 1);
        chk("sat_wdat", bus.wb_wdat, 32'h5A5A);
        tick();
        bus.dhit = 1'b0;
        #1;
        chk("sat_hold", bus.stall_cnt, 32'hFFFF);
        chk("sat_idle_dren", bus.dmemREN, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
